ssm_input_loader: RTL

- Upstream feeder for ssm_block_fp16_top.
- Accepts one fp16 word per handshake on a valid/ready stream and deserialises one token's operands into the flat buses that block consumes: dt, dA, Bmat, C, D, x and h_prev.
- Issues a one-cycle start, then holds all buses stable until the core reports done, then reopens for the next token.

---
 rtl/ssm_input_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ssm_input_loader.sv
// Deserialises one token's fp16 operand stream (DT, DA, BM, CM, DD, X, optional HP) into the
// flat buses of ssm_block_fp16_top; start pulses 1 cycle after the last word, buses hold until core_done.
module ssm_input_loader #(
   parameter int B  = 1,
   parameter int H  = 4,
   parameter int P  = 4,
   parameter int N  = 4,
   parameter int DW = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW-1:0]           in_data,
   input  logic                    in_last,
   input  logic                    load_h,
   input  logic                    core_done,
   output logic                    start,
   output logic                    busy,
   output logic                    frame_err,
   output logic [B*H*DW-1:0]       dt_flat,
   output logic [B*H*DW-1:0]       dA_flat,
   output logic [B*N*DW-1:0]       Bmat_flat,
   output logic [B*N*DW-1:0]       C_flat,
   output logic [H*DW-1:0]         D_flat,
   output logic [B*H*P*DW-1:0]     x_flat,
   output logic [B*H*P*N*DW-1:0]   h_prev_flat
);
   localparam int N_DT = B*H;
   localparam int N_BM = B*N;
   localparam int N_DD = H;
   localparam int N_X  = B*H*P;
   localparam int N_HP = B*H*P*N;
   localparam int IW   = $clog2(N_HP + 1);

   typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_WAIT} state_t;
   typedef enum logic [2:0] {SEG_DT, SEG_DA, SEG_BM, SEG_CM, SEG_DD, SEG_X, SEG_HP} seg_t;

   state_t                  state_q, state_d;
   seg_t                    seg_q, seg_d;
   logic [IW-1:0]           idx_q, idx_d, seg_last;
   logic                    load_h_q, load_h_d;
   logic                    ferr_q, ferr_d;
   logic [N_DT*DW-1:0]      dt_q, dt_d, da_q, da_d;
   logic [N_BM*DW-1:0]      bm_q, bm_d, cm_q, cm_d;
   logic [N_DD*DW-1:0]      dd_q, dd_d;
   logic [N_X*DW-1:0]       x_q, x_d;
   logic [N_HP*DW-1:0]      hp_q, hp_d;

   logic accept, first_word, eff_load_h, at_seg_end, exp_last;

   assign in_ready   = (state_q == ST_LOAD);
   assign accept     = in_valid && in_ready;
   assign first_word = (seg_q == SEG_DT) && (idx_q == '0);
   // The frame's own load_h applies already to its first word's end-of-frame decision.
   assign eff_load_h = first_word ? load_h : load_h_q;
   assign at_seg_end = (idx_q == seg_last);
   assign exp_last   = at_seg_end && ((seg_q == SEG_HP) || (seg_q == SEG_X && !eff_load_h));

   always_comb begin
      seg_last = '0;
      case (seg_q)
         SEG_DT, SEG_DA: seg_last = IW'(N_DT - 1);
         SEG_BM, SEG_CM: seg_last = IW'(N_BM - 1);
         SEG_DD:         seg_last = IW'(N_DD - 1);
         SEG_X:          seg_last = IW'(N_X - 1);
         default:        seg_last = IW'(N_HP - 1);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      seg_d    = seg_q;
      idx_d    = idx_q;
      load_h_d = load_h_q;
      ferr_d   = 1'b0;
      dt_d     = dt_q;
      da_d     = da_q;
      bm_d     = bm_q;
      cm_d     = cm_q;
      dd_d     = dd_q;
      x_d      = x_q;
      hp_d     = hp_q;

      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (first_word) load_h_d = load_h;
               case (seg_q)
                  SEG_DT: for (int k = 0; k < N_DT; k++) if (idx_q == IW'(k)) dt_d[k*DW +: DW] = in_data;
                  SEG_DA: for (int k = 0; k < N_DT; k++) if (idx_q == IW'(k)) da_d[k*DW +: DW] = in_data;
                  SEG_BM: for (int k = 0; k < N_BM; k++) if (idx_q == IW'(k)) bm_d[k*DW +: DW] = in_data;
                  SEG_CM: for (int k = 0; k < N_BM; k++) if (idx_q == IW'(k)) cm_d[k*DW +: DW] = in_data;
                  SEG_DD: for (int k = 0; k < N_DD; k++) if (idx_q == IW'(k)) dd_d[k*DW +: DW] = in_data;
                  SEG_X:  for (int k = 0; k < N_X;  k++) if (idx_q == IW'(k)) x_d[k*DW +: DW]  = in_data;
                  default: for (int k = 0; k < N_HP; k++) if (idx_q == IW'(k)) hp_d[k*DW +: DW] = in_data;
               endcase

               if (exp_last) begin
                  state_d = ST_FIRE;
                  seg_d   = SEG_DT;
                  idx_d   = '0;
                  ferr_d  = !in_last;
               end else if (in_last) begin
                  // Early in_last: abandon the frame, keep what was written, resync at DT/0.
                  ferr_d = 1'b1;
                  seg_d  = SEG_DT;
                  idx_d  = '0;
               end else if (at_seg_end) begin
                  seg_d = seg_t'(seg_q + 3'd1);
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_FIRE: state_d = ST_WAIT;
         ST_WAIT: if (core_done) state_d = ST_LOAD;
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         seg_q    <= SEG_DT;
         idx_q    <= '0;
         load_h_q <= 1'b0;
         ferr_q   <= 1'b0;
         dt_q     <= '0;
         da_q     <= '0;
         bm_q     <= '0;
         cm_q     <= '0;
         dd_q     <= '0;
         x_q      <= '0;
         hp_q     <= '0;
      end else begin
         state_q  <= state_d;
         seg_q    <= seg_d;
         idx_q    <= idx_d;
         load_h_q <= load_h_d;
         ferr_q   <= ferr_d;
         dt_q     <= dt_d;
         da_q     <= da_d;
         bm_q     <= bm_d;
         cm_q     <= cm_d;
         dd_q     <= dd_d;
         x_q      <= x_d;
         hp_q     <= hp_d;
      end
   end

   assign start       = (state_q == ST_FIRE);
   assign busy        = (state_q != ST_LOAD);
   assign frame_err   = ferr_q;
   assign dt_flat     = dt_q;
   assign dA_flat     = da_q;
   assign Bmat_flat   = bm_q;
   assign C_flat      = cm_q;
   assign D_flat      = dd_q;
   assign x_flat      = x_q;
   assign h_prev_flat = hp_q;
endmodule
